// File: rtl/instr_encoder_loader_pkg.sv
// Shared op, opcode and funct definitions for the instruction encoder/loader.
// The opcode/funct constants are the same ones the single-cycle Controller decodes.
package instr_encoder_loader_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SLT  = 5'd4,
        OP_ADDI = 5'd5,
        OP_XORI = 5'd6,
        OP_SLTI = 5'd7,
        OP_ORI  = 5'd8,
        OP_LW   = 5'd9,
        OP_SW   = 5'd10,
        OP_BEQ  = 5'd11,
        OP_BNE  = 5'd12,
        OP_BLT  = 5'd13,
        OP_BGE  = 5'd14,
        OP_LUI  = 5'd15,
        OP_JAL  = 5'd16,
        OP_JALR = 5'd17
    } op_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    // BGE/BLT are swapped relative to the base ISA to match the core's decoder.
    localparam logic [2:0] F3_BGE  = 3'b100;
    localparam logic [2:0] F3_BLT  = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    function automatic logic fits_i(input logic [31:0] imm);
        return (&imm[31:11]) | ~(|imm[31:11]);
    endfunction

    function automatic logic fits_b(input logic [31:0] imm);
        return ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    endfunction

    function automatic logic fits_j(input logic [31:0] imm);
        return ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
    endfunction

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational RV32I packer: symbolic op + fields + immediate -> instruction word,
// plus illegal-op and immediate-range flags.
module rv_instr_pack
    import instr_encoder_loader_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        range_err_o
);

    fmt_e       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] word;
    logic       rng_ok;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        fmt       = FMT_R;
        opc       = '0;
        f3        = '0;
        f7        = F7_BASE;
        illegal_o = 1'b0;
        case (op_e'(op_i))
            OP_ADD:  begin opc = OPC_OP; f3 = F3_ADD; end
            OP_SUB:  begin opc = OPC_OP; f3 = F3_ADD; f7 = F7_SUB; end
            OP_AND:  begin opc = OPC_OP; f3 = F3_AND; end
            OP_OR:   begin opc = OPC_OP; f3 = F3_OR;  end
            OP_SLT:  begin opc = OPC_OP; f3 = F3_SLT; end
            OP_ADDI: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_ADD; end
            OP_XORI: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_XOR; end
            OP_SLTI: begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_SLT; end
            OP_ORI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_OR;  end
            OP_LW:   begin fmt = FMT_I; opc = OPC_LOAD;   f3 = F3_WORD; end
            OP_JALR: begin fmt = FMT_I; opc = OPC_JALR;   f3 = F3_ADD; end
            OP_SW:   begin fmt = FMT_S; opc = OPC_STORE;  f3 = F3_WORD; end
            OP_BEQ:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ; end
            OP_BNE:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE; end
            OP_BLT:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLT; end
            OP_BGE:  begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGE; end
            OP_LUI:  begin fmt = FMT_U; opc = OPC_LUI; end
            OP_JAL:  begin fmt = FMT_J; opc = OPC_JAL; end
            default: illegal_o = 1'b1;
        endcase
    end

    // Fields a format does not carry are simply left out of the concatenation, i.e. zero.
    always_comb begin
        word   = '0;
        rng_ok = 1'b1;
        case (fmt)
            FMT_R: word = {f7, rs2_i, rs1_i, f3, rd_i, opc};
            FMT_I: begin
                word   = {imm_i[11:0], rs1_i, f3, rd_i, opc};
                rng_ok = fits_i(imm_i);
            end
            FMT_S: begin
                word   = {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], opc};
                rng_ok = fits_i(imm_i);
            end
            FMT_B: begin
                word   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3, imm_i[4:1], imm_i[11], opc};
                rng_ok = fits_b(imm_i);
            end
            FMT_U: begin
                word   = {imm_i[31:12], rd_i, opc};
                rng_ok = (imm_i[11:0] == 12'd0);
            end
            FMT_J: begin
                word   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opc};
                rng_ok = fits_j(imm_i);
            end
            default: word = '0;
        endcase
        word_o      = illegal_o ? 32'd0 : word;
        range_err_o = ~illegal_o & ~rng_ok;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts symbolic instruction requests, encodes them and writes legal words
// sequentially into instruction memory, one word per two cycles.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int          DEPTH_W   = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         in_op,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [31:0]        in_imm,
    input  logic               in_last,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [DEPTH_W:0]   count,
    output logic               done,
    output logic               full,
    output logic               err_illegal,
    output logic               err_range
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [DEPTH_W:0] DEPTH = {1'b1, {DEPTH_W{1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [DEPTH_W:0] count_q, count_d, count_inc;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             full_q, full_d;
    logic             err_ill_q, err_ill_d;
    logic             err_rng_q, err_rng_d;

    logic [31:0] pk_word;
    logic        pk_illegal;
    logic        pk_range;

    rv_instr_pack u_pack (
        .op_i        (in_op),
        .rd_i        (in_rd),
        .rs1_i       (in_rs1),
        .rs2_i       (in_rs2),
        .imm_i       (in_imm),
        .word_o      (pk_word),
        .illegal_o   (pk_illegal),
        .range_err_o (pk_range)
    );

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        last_d    = last_q;
        done_d    = done_q;
        full_d    = full_q;
        err_ill_d = err_ill_q;
        err_rng_d = err_rng_q;
        if (start) begin
            state_d   = S_ACCEPT;
            count_d   = '0;
            addr_d    = BASE_ADDR;
            done_d    = 1'b0;
            full_d    = 1'b0;
            err_ill_d = 1'b0;
            err_rng_d = 1'b0;
        end else begin
            case (state_q)
                S_ACCEPT: begin
                    if (in_valid) begin
                        if (pk_illegal) begin
                            err_ill_d = 1'b1;
                        end else if (pk_range) begin
                            err_rng_d = 1'b1;
                        end else begin
                            wdata_d = pk_word;
                            addr_d  = BASE_ADDR + (32'(count_q) << 2);
                            last_d  = in_last;
                            state_d = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    count_d = count_inc;
                    // in_last takes precedence so done and full never rise together.
                    if (last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (count_inc == DEPTH) begin
                        state_d = S_DONE;
                        full_d  = 1'b1;
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end
                S_IDLE, S_DONE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: reset here is synchronous and active-high, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            full_q    <= 1'b0;
            err_ill_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            last_q    <= last_d;
            done_q    <= done_d;
            full_q    <= full_d;
            err_ill_q <= err_ill_d;
            err_rng_q <= err_rng_d;
        end
    end

    // A start or reset arriving in the write cycle cancels that write.
    assign mem_we      = (state_q == S_WRITE) & ~start & ~rst;
    assign in_ready    = (state_q == S_ACCEPT);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign count       = count_q;
    assign done        = done_q;
    assign full        = full_q;
    assign err_illegal = err_ill_q;
    assign err_range   = err_rng_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder/writer counterpart of the core's single-cycle Controller. It accepts symbolic instruction requests (op enum, register fields, immediate) over a valid/ready handshake.
- Each request is encoded into an RV32I word for the subset the Controller decodes. Legal words are written sequentially into instruction memory.
- Used by testbenches and the boot path to load programs into the instruction memory before the core is released from reset.

Parameters:
- DEPTH_W, 10, log2 of instruction-memory capacity in words. Capacity DEPTH = 2**DEPTH_W.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written. Must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: clear pointer and errors, open for requests
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request this cycle
- in_op  in  5  op enum, see Decomposition
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  signed byte immediate. For LUI, the full 32-bit value.
- in_last  in  1  request is the final instruction of the program
- mem_we  out  1  instruction-memory write strobe, one cycle per word
- mem_addr  out  32  byte address = BASE_ADDR + 4*count
- mem_wdata  out  32  encoded instruction word
- count  out  DEPTH_W+1  number of words written since start
- done  out  1  program complete (last written)
- full  out  1  memory capacity reached
- err_illegal  out  1  sticky: unsupported op seen
- err_range  out  1  sticky: immediate not encodable

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=S_IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, done=0, full=0, err_illegal=0, err_range=0. Reset asserted during S_WRITE wins: no write occurs on that edge or later.
- FSM states: S_IDLE, S_ACCEPT, S_WRITE, S_DONE.
  - S_IDLE: in_ready=0. start -> S_ACCEPT.
  - S_ACCEPT: in_ready=1. in_valid&in_ready at edge N:
    - Legal op with an in-range immediate: latch the encoded word, mem_addr and in_last, then go to S_WRITE.
    - Illegal op: set err_illegal, stay in S_ACCEPT, count unchanged, no write.
    - Immediate out of range: set err_range, stay in S_ACCEPT, count unchanged, no write.
  - S_WRITE: mem_we=1 for exactly one cycle (cycle N+1), in_ready=0. count increments at the end of the cycle. Next state:
    - in_last=1 -> S_DONE with done=1.
    - count+1 == DEPTH -> S_DONE with full=1.
    - Otherwise -> S_ACCEPT.
  - S_DONE: in_ready=0. Holds until start or rst.
- Throughput: one word per 2 cycles. Write latency is 1 cycle after acceptance.
- start: honoured in any state and takes priority over in_valid in the same cycle. It sets count=0, mem_addr=BASE_ADDR, clears done, full and both err flags, suppresses any pending write, and moves to S_ACCEPT.
- Encoding (opcode / funct3 / funct7):
  - R-type 0110011: ADD 000/0000000, SUB 000/0100000, AND 111/0, OR 110/0, SLT 010/0.
  - I-type 0010011: ADDI 000, XORI 100, SLTI 010, ORI 110.
  - LW: 0000011, funct3 010. JALR: 1100111, funct3 000.
  - SW: 0100011, funct3 010.
  - Branches 1100011: BEQ 000, BNE 001, BGE 100, BLT 101. The BGE/BLT funct3 values match the core's decoder; this deliberate swap is mandatory.
  - LUI 0110111. JAL 1101111.
- Unused fields are forced to zero: rs1/rs2 for U/J formats, rs2 for I format, rd for S/B formats.
- Immediate range checks:
  - I and S formats: -2048..2047.
  - B format: -4096..4094, must be even.
  - J format: -1048576..1048574, must be even.
  - U format: in_imm[11:0] must be 0.
  - Any violation sets err_range.
- done and full are never both set by one write. When in_last=1 on the final slot, done wins.

Decomposition:
- Shared package: op enum constants (ADD=0, SUB=1, AND=2, OR=3, SLT=4, ADDI=5, XORI=6, SLTI=7, ORI=8, LW=9, SW=10, BEQ=11, BNE=12, BLT=13, BGE=14, LUI=15, JAL=16, JALR=17; 18..31 illegal).
- The same package holds the opcode, funct3 and funct7 constants, shared with the Controller.
- One combinational sub-module, rv_instr_pack: op + fields + imm -> {word, illegal, range_err}. The FSM, pointer and handshake stay in the top.

Test Plan:
- start, then ADDI x1,x0,5 -> mem_we one cycle later, mem_addr=0x0, mem_wdata=0x00500093, count=1.
- Back-to-back ADD x3,x1,x2 then SUB x3,x1,x2 with in_valid held -> in_ready toggles 1/0. Words 0x002081B3 then 0x402081B3 are written at 0x0 and 0x4.
- Encodings:
  - SW x2,8(x1) -> 0x0020A423.
  - BEQ x1,x2,-4 -> 0xFE208EE3.
  - JAL x1,8 -> 0x008000EF.
  - LUI x5,0x12345000 -> 0x123452B7.
  - BGE x1,x2,0 -> funct3=100.
- ADDI imm=2048 -> err_range=1, no mem_we, count unchanged. in_op=20 -> err_illegal=1, no write. Both flags stay set until start.
- DEPTH_W=2: five requests -> four writes, full=1 after the 4th, in_ready=0. in_last on the 4th instead -> done=1, full=0.
- rst asserted in the S_WRITE cycle -> mem_we=0 from the next edge, count=0. start together with in_valid -> request ignored, count=0.
